// File: rtl/id_stage_if.sv
// Bundle between fetch/write-back drivers and the decode stage.
// The decode stage uses the slave modport; whoever feeds it uses master.
interface id_stage_if #(
    parameter int WIDTH = 32
);
    // fetch side
    logic [31:0]      instruction;
    logic [WIDTH-1:0] PC;
    logic             stall;
    logic             flush;

    // register-file write-back port
    logic             wb_en;
    logic [4:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;

    // decoded outputs
    logic [WIDTH-1:0] id_pc;
    logic             valid;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [4:0]       rd_addr;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [WIDTH-1:0] imm;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             alu_src;
    logic             mem_to_reg;
    logic [1:0]       alu_op;
    logic             illegal;

    modport master (
        output instruction, PC, stall, flush, wb_en, wb_addr, wb_data,
        input  id_pc, valid, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data,
               imm, funct3, funct7_5, reg_write, mem_read, mem_write, branch,
               jump, alu_src, mem_to_reg, alu_op, illegal
    );

    modport slave (
        input  instruction, PC, stall, flush, wb_en, wb_addr, wb_data,
        output id_pc, valid, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data,
               imm, funct3, funct7_5, reg_write, mem_read, mem_write, branch,
               jump, alu_src, mem_to_reg, alu_op, illegal
    );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID pipeline register with stall/flush,
// RV32I-style control decode, immediate generation and a 32-entry
// register file with a write-through bypass on the read ports.
// All outputs are combinational from the IF/ID register and the file.
module id_stage #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    id_stage_if.slave bus
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [31:0]      ifid_instr;
    logic [WIDTH-1:0] ifid_pc;
    logic             ifid_valid;

    logic [WIDTH-1:0] regs [32];

    logic             wb_fire;
    logic [6:0]       opcode;

    logic             dec_reg_write;
    logic             dec_mem_read;
    logic             dec_mem_write;
    logic             dec_branch;
    logic             dec_jump;
    logic             dec_alu_src;
    logic             dec_mem_to_reg;
    logic             dec_illegal;
    logic [1:0]       dec_alu_op;
    logic [WIDTH-1:0] dec_imm;

    assign wb_fire = bus.wb_en && (bus.wb_addr != 5'd0);
    assign opcode  = ifid_instr[6:0];

    // IF/ID register: flush beats stall beats load; a flushed slot keeps the PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (bus.flush) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= bus.PC;
            ifid_valid <= 1'b0;
        end else if (!bus.stall) begin
            ifid_instr <= bus.instruction;
            ifid_pc    <= bus.PC;
            ifid_valid <= 1'b1;
        end
    end

    // Register file write port; x0 is never written, independent of stall/flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_fire) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Operand reads: x0 is hard zero, a same-cycle write to the read address bypasses storage.
    always_comb begin
        bus.rs1_data = regs[ifid_instr[19:15]];
        bus.rs2_data = regs[ifid_instr[24:20]];
        if (ifid_instr[19:15] == 5'd0) begin
            bus.rs1_data = '0;
        end else if (wb_fire && (bus.wb_addr == ifid_instr[19:15])) begin
            bus.rs1_data = bus.wb_data;
        end
        if (ifid_instr[24:20] == 5'd0) begin
            bus.rs2_data = '0;
        end else if (wb_fire && (bus.wb_addr == ifid_instr[24:20])) begin
            bus.rs2_data = bus.wb_data;
        end
    end

    // Opcode decode into raw controls and the format-specific immediate.
    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_alu_src    = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_illegal    = 1'b0;
        dec_alu_op     = 2'b00;
        dec_imm        = '0;
        unique case (opcode)
            OP_R: begin
                dec_reg_write = 1'b1;
                dec_alu_op    = 2'b10;
            end
            OP_I_ALU: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = 2'b11;
                dec_imm       = {{(WIDTH-12){ifid_instr[31]}}, ifid_instr[31:20]};
            end
            OP_LOAD: begin
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_src    = 1'b1;
                dec_imm        = {{(WIDTH-12){ifid_instr[31]}}, ifid_instr[31:20]};
            end
            OP_STORE: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = {{(WIDTH-12){ifid_instr[31]}},
                                 ifid_instr[31:25], ifid_instr[11:7]};
            end
            OP_BRANCH: begin
                dec_branch = 1'b1;
                dec_alu_op = 2'b01;
                dec_imm    = {{(WIDTH-12){ifid_instr[31]}}, ifid_instr[7],
                              ifid_instr[30:25], ifid_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = {{(WIDTH-32){ifid_instr[31]}}, ifid_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = {{(WIDTH-20){ifid_instr[31]}}, ifid_instr[19:12],
                                 ifid_instr[20], ifid_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = {{(WIDTH-12){ifid_instr[31]}}, ifid_instr[31:20]};
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Output stage: every control is qualified by valid so bubbles and reset are inert.
    always_comb begin
        bus.id_pc      = ifid_pc;
        bus.valid      = ifid_valid;
        bus.rs1_addr   = ifid_instr[19:15];
        bus.rs2_addr   = ifid_instr[24:20];
        bus.rd_addr    = ifid_instr[11:7];
        bus.funct3     = ifid_instr[14:12];
        bus.funct7_5   = ifid_instr[30];
        bus.imm        = dec_imm;
        bus.reg_write  = dec_reg_write  & ifid_valid;
        bus.mem_read   = dec_mem_read   & ifid_valid;
        bus.mem_write  = dec_mem_write  & ifid_valid;
        bus.branch     = dec_branch     & ifid_valid;
        bus.jump       = dec_jump       & ifid_valid;
        bus.alu_src    = dec_alu_src    & ifid_valid;
        bus.mem_to_reg = dec_mem_to_reg & ifid_valid;
        bus.illegal    = dec_illegal    & ifid_valid;
        bus.alu_op     = dec_alu_op     & {2{ifid_valid}};
    end
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a reference decode model pushes expected IF/ID
// results into a queue as each instruction is driven; after the edge the
// entry is popped and compared. Spot checks use hand-computed constants.
module tb_id_stage;
    localparam int WIDTH = 32;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7;
        logic [9:0]  ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t        sb_q[$];
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_rf [32];

    id_stage_if #(.WIDTH(WIDTH)) bus ();

    id_stage #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // packing: {reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg, illegal, alu_op}
    function automatic logic [31:0] dut_ctrl();
        return {22'b0, bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.jump,
                bus.alu_src, bus.mem_to_reg, bus.illegal, bus.alu_op};
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc, input logic v);
        exp_t e;
        logic [9:0]  c;
        logic [31:0] im;
        c  = '0;
        im = '0;
        case (i[6:0])
            7'b0110011: c = 10'b1000000010;
            7'b0010011: begin c = 10'b1000010011; im = {{20{i[31]}}, i[31:20]}; end
            7'b0000011: begin c = 10'b1100011000; im = {{20{i[31]}}, i[31:20]}; end
            7'b0100011: begin c = 10'b0010010000; im = {{20{i[31]}}, i[31:25], i[11:7]}; end
            7'b1100011: begin c = 10'b0001000001;
                              im = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; end
            7'b0110111, 7'b0010111: begin c = 10'b1000010000; im = {i[31:12], 12'b0}; end
            7'b1101111: begin c = 10'b1000110000;
                              im = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
            7'b1100111: begin c = 10'b1000110000; im = {{20{i[31]}}, i[31:20]}; end
            default:    c = 10'b0000000100;
        endcase
        e.valid = v;
        e.pc    = pc;
        e.imm   = im;
        e.rs1   = i[19:15];
        e.rs2   = i[24:20];
        e.rd    = i[11:7];
        e.f3    = i[14:12];
        e.f7    = i[30];
        e.ctrl  = v ? c : 10'b0;
        return e;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
        return m_rf[a];
    endfunction

    task automatic model_reset();
        m_instr = 32'h0000_0013;
        m_pc    = '0;
        m_valid = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        sb_q.delete();
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.wb_en   = en;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    // drive one cycle of fetch input, push expectation, then pop and compare after the edge
    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic st, input logic fl);
        exp_t e;
        @(negedge clk);
        bus.instruction = instr;
        bus.PC          = pc;
        bus.stall       = st;
        bus.flush       = fl;
        if (fl) begin
            m_instr = 32'h0000_0013; m_pc = pc; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = instr; m_pc = pc; m_valid = 1'b1;
        end
        sb_q.push_back(ref_decode(m_instr, m_pc, m_valid));
        @(posedge clk);
        if (bus.wb_en && bus.wb_addr != 5'd0) m_rf[bus.wb_addr] = bus.wb_data;
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("valid",    {31'b0, bus.valid}, {31'b0, e.valid});
            chk("id_pc",    bus.id_pc, e.pc);
            chk("imm",      bus.imm, e.imm);
            chk("rs1_addr", {27'b0, bus.rs1_addr}, {27'b0, e.rs1});
            chk("rs2_addr", {27'b0, bus.rs2_addr}, {27'b0, e.rs2});
            chk("rd_addr",  {27'b0, bus.rd_addr}, {27'b0, e.rd});
            chk("funct",    {28'b0, bus.funct3, bus.funct7_5}, {28'b0, e.f3, e.f7});
            chk("ctrl",     dut_ctrl(), {22'b0, e.ctrl});
            chk("rs1_data", bus.rs1_data, m_read(e.rs1));
            chk("rs2_data", bus.rs2_data, m_read(e.rs2));
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.instruction = 32'h0;
        bus.PC          = 32'h0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        model_reset();
        #12;
        chk("rst_valid", {31'b0, bus.valid}, 32'h0);
        chk("rst_id_pc", bus.id_pc, 32'h0);
        chk("rst_imm",   bus.imm, 32'h0);
        chk("rst_ctrl",  dut_ctrl(), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // addi x1,x0,5
        drive(32'h0050_0093, 32'h10, 1'b0, 1'b0);
        chk("addi_valid", {31'b0, bus.valid}, 32'h1);
        chk("addi_pc",    bus.id_pc, 32'h10);
        chk("addi_rd",    {27'b0, bus.rd_addr}, 32'd1);
        chk("addi_imm",   bus.imm, 32'h5);
        chk("addi_ctrl",  dut_ctrl(), 32'b1000010011);
        chk("addi_rs1d",  bus.rs1_data, 32'h0);

        // beq x1,x2,-8
        drive(32'hFE20_8CE3, 32'h14, 1'b0, 1'b0);
        chk("beq_ctrl", dut_ctrl(), 32'b0001000001);
        chk("beq_imm",  bus.imm, 32'hFFFF_FFF8);
        chk("beq_rs",   {22'b0, bus.rs1_addr, bus.rs2_addr}, {22'b0, 5'd1, 5'd2});

        // same-cycle bypass into rs1, then stall twice with changing fetch input
        set_wb(1'b1, 5'd1, 32'h1234);
        #1;
        chk("bypass_rs1", bus.rs1_data, 32'h1234);
        drive(32'hDEAD_BEEF, 32'h18, 1'b1, 1'b0);
        set_wb(1'b0, 5'd0, 32'h0);
        #1;
        chk("stored_rs1", bus.rs1_data, 32'h1234);
        drive(32'h1234_5678, 32'h1C, 1'b1, 1'b0);
        chk("stall_pc",   bus.id_pc, 32'h14);
        chk("stall_ctrl", dut_ctrl(), 32'b0001000001);

        // write to x0 is dropped and never bypassed
        set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        drive(32'h0000_0033, 32'h20, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0, 32'h0);
        #1;
        chk("x0_read", bus.rs1_data, 32'h0);

        // flush and stall together: bubble
        drive(32'h0050_0093, 32'h24, 1'b1, 1'b1);
        chk("flush_valid", {31'b0, bus.valid}, 32'h0);
        chk("flush_ctrl",  dut_ctrl(), 32'h0);

        // a mix of formats checked against the model, with writes landing along the way
        set_wb(1'b1, 5'd5, 32'hCAFE_0005);
        drive(32'h0080_A283, 32'h28, 1'b0, 1'b0);   // lw x5,8(x1)
        set_wb(1'b0, 5'd0, 32'h0);
        drive(32'h0050_A623, 32'h2C, 1'b0, 1'b0);   // sw x5,12(x1)
        drive(32'h1234_51B7, 32'h30, 1'b0, 1'b0);   // lui x3,0x12345
        drive(32'h0000_1117, 32'h34, 1'b0, 1'b0);   // auipc x2,1
        drive(32'h8010_00EF, 32'h38, 1'b0, 1'b0);   // jal, negative offset
        drive(32'hFFC0_80E7, 32'h3C, 1'b0, 1'b0);   // jalr x1,-4(x1)
        drive(32'h4020_8133, 32'h40, 1'b0, 1'b0);   // sub x2,x1,x2

        // unsupported opcode
        drive(32'h0000_007F, 32'h44, 1'b0, 1'b0);
        chk("ill_ctrl", dut_ctrl(), 32'b0000000100);

        // asynchronous reset mid-cycle
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, bus.valid}, 32'h0);
        chk("arst_pc",    bus.id_pc, 32'h0);
        chk("arst_ctrl",  dut_ctrl(), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(32'hFE20_8CE3, 32'h50, 1'b0, 1'b0);
        chk("arst_x1", bus.rs1_data, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage that sits directly downstream of the fetch stage.
- Latches the fetched `instruction` and `PC` into an internal IF/ID pipeline register, with stall and flush support.
- Decodes the latched instruction into control signals and a sign-extended immediate.
- Reads two operands from a 32-entry integer register file. The file has a write-back port and a write-through bypass.

Parameters:
- WIDTH, 32, datapath/PC width in bits; matches the fetch stage PC width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- instruction  input  32  fetched instruction from the fetch stage.
- PC  input  WIDTH  address of `instruction`.
- stall  input  1  hold the IF/ID register.
- flush  input  1  replace the IF/ID contents with a bubble.
- wb_en  input  1  register-file write enable.
- wb_addr  input  5  write-back destination.
- wb_data  input  WIDTH  write-back value.
- id_pc  output  WIDTH  PC of the decoded instruction.
- valid  output  1  decoded instruction is real (not a bubble).
- rs1_addr, rs2_addr, rd_addr  output  5 each  register fields.
- rs1_data, rs2_data  output  WIDTH each  operand values.
- imm  output  WIDTH  sign-extended immediate.
- funct3  output  3  instr[14:12].
- funct7_5  output  1  instr[30].
- reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg  output  1 each  control signals.
- alu_op  output  2  ALU class: 00 add, 01 branch-compare, 10 R-type, 11 I-type ALU.
- illegal  output  1  unsupported opcode in a valid slot.

Behaviour:
- Reset (async, `rst`=1):
  - IF/ID instr = 0x00000013, IF/ID pc = 0, IF/ID valid = 0.
  - All 32 registers are cleared to 0.
  - Consequently all control outputs are 0, `imm` = 0, `id_pc` = 0.
- IF/ID register, on each clk edge, priority flush > stall > load:
  - flush: instr = 0x00000013, valid = 0, pc = `PC`.
  - stall: hold all fields.
  - otherwise: capture `instruction`, `PC`, valid = 1.
- Latency: an instruction presented before edge k appears decoded on the outputs after edge k, i.e. one cycle. All outputs are combinational from IF/ID state plus the register file.
- Control outputs (reg_write, mem_read, mem_write, branch, jump, illegal) are ANDed with `valid`. A bubble or reset state drives all of them to 0.
- Decode by opcode instr[6:0]; controls not listed are 0:
  - 0110011 R: reg_write, alu_op = 10.
  - 0010011 I-ALU: reg_write, alu_src, alu_op = 11.
  - 0000011 load: reg_write, mem_read, mem_to_reg, alu_src, alu_op = 00.
  - 0100011 store: mem_write, alu_src, alu_op = 00.
  - 1100011 branch: branch, alu_op = 01.
  - 0110111 LUI, 0010111 AUIPC: reg_write, alu_src, alu_op = 00.
  - 1101111 JAL, 1100111 JALR: reg_write, jump, alu_src, alu_op = 00.
  - any other opcode: illegal = 1, all other controls 0.
- Immediate, sign bit instr[31] replicated to WIDTH:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type and illegal: 0.
- Register fields: rs1_addr = instr[19:15], rs2_addr = instr[24:20], rd_addr = instr[11:7]. These are output for every format, regardless of use.
- Register file writes:
  - Write on clk edge when wb_en = 1 and wb_addr != 0.
  - Writes to x0 are discarded; x0 always reads 0.
  - Writes are independent of stall and flush.
- Read bypass: if wb_en = 1, wb_addr != 0 and wb_addr equals a read address, that read returns `wb_data` in the same cycle.
- Simultaneous stall and flush: flush wins.
- `rst` asserted mid-operation: immediate return to the reset state; no write completes.

Test Plan:
- Reset then release; drive `instruction` = 0x00500093 (addi x1,x0,5), PC = 0x10. After 1 edge: valid = 1, id_pc = 0x10, rd_addr = 1, imm = 0x00000005, reg_write = 1, alu_src = 1, alu_op = 11, rs1_data = 0.
- Drive 0xFE208CE3 (beq x1,x2,-8). Required: branch = 1, alu_op = 01, imm = 0xFFFFFFF8, rs1_addr = 1, rs2_addr = 2, reg_write = 0.
- Bypass: wb_en = 1, wb_addr = 1, wb_data = 0x1234 while decoding rs1 = 1. Required: rs1_data = 0x1234 in the same cycle, and the next cycle reads 0x1234 from storage.
- Write to x0: wb_en = 1, wb_addr = 0, wb_data = 0xFFFFFFFF. Required: a later read of x0 gives 0.
- Stall for 2 cycles while `instruction` changes. Required: outputs unchanged. Then assert flush and stall together: valid = 0, all controls 0.
- Drive opcode 0x7F (0x0000007F). Required: illegal = 1, all other controls 0. Assert `rst` mid-cycle: outputs return to reset values before the next edge.
